// File: rtl/gate_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : gate_checker_if
// Description : Run-control, DUT-vector and result bundle of gate_checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface gate_checker_if #(
    parameter int N_IN = 2
);
    logic              start;
    logic [N_IN-1:0]   dut_in;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     err_count;
    logic              fail_valid;
    logic [N_IN-1:0]   fail_vec;

    // master: the environment that launches runs and hosts the chip under test
    modport master (
        output start,
        output dut_out,
        input  dut_in,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  fail_vec
    );

    modport slave (
        input  start,
        input  dut_out,
        output dut_in,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output fail_vec
    );
endinterface
`default_nettype wire

// File: rtl/gate_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_checker
// Description : Walks every input vector of a single-output gate, compares the
//               sampled output with a truth table and reports the results.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_checker #(
    parameter int                   N_IN  = 2,
    parameter logic [2**N_IN-1:0]   TRUTH = 4'b1000,
    parameter int                   HOLD  = 10
) (
    input  wire logic      clk,
    input  wire logic      reset,
    gate_checker_if.slave  bus
);
    localparam int                c_cnt_w    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [c_cnt_w-1:0] c_hold_rld = c_cnt_w'(HOLD - 1);
    localparam logic [N_IN-1:0]   c_last_vec = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [N_IN-1:0]     r_vec;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [N_IN:0]       r_err;
    logic                r_fail_valid;
    logic [N_IN-1:0]     r_fail_vec;
    logic                w_mismatch;
    logic                w_busy;
    logic                w_done;

    // X or Z on the gate output must be treated as a failure, hence the 4-state compare
    assign w_mismatch = (bus.dut_out !== TRUTH[r_vec]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next_state = S_DRIVE;
            S_DRIVE:  if (r_cnt == '0) w_next_state = S_SAMPLE;
            S_SAMPLE: w_next_state = (r_vec == c_last_vec) ? S_DONE : S_DRIVE;
            S_DONE:   if (bus.start) w_next_state = S_DRIVE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec        <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_vec        <= '0;
                        r_cnt        <= c_hold_rld;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_vec   <= '0;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_SAMPLE: begin
                    if (w_mismatch) begin
                        r_err <= r_err + 1'b1;
                        if (!r_fail_valid) begin
                            r_fail_valid <= 1'b1;
                            r_fail_vec   <= r_vec;
                        end
                    end
                    // The terminal vector leaves for DONE without incrementing, so no wrap
                    if (r_vec != c_last_vec) begin
                        r_vec <= r_vec + 1'b1;
                        r_cnt <= c_hold_rld;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode flops only; start and dut_out never reach them combinationally
    assign w_busy         = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign w_done         = (r_state == S_DONE);
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.dut_in     = w_busy ? r_vec : '0;
    assign bus.pass       = w_done && (r_err == '0);
    assign bus.err_count  = r_err;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_vec   = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_checker
// Description : Directed bench for gate_checker with a run-result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_checker;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_checker_if #(.N_IN(2)) bus_a ();
    gate_checker_if #(.N_IN(2)) bus_x ();

    int mode_a;

    // 0 = And, 1 = stuck-at-0, 2 = Nand, other = Xor
    function automatic logic dut_model(input int mode, input logic [1:0] v);
        case (mode)
            0:       return v[0] & v[1];
            1:       return 1'b0;
            2:       return ~(v[0] & v[1]);
            default: return v[0] ^ v[1];
        endcase
    endfunction

    assign bus_a.dut_out = dut_model(mode_a, bus_a.dut_in);
    assign bus_x.dut_out = dut_model(3, bus_x.dut_in);

    gate_checker u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    gate_checker #(.N_IN(2), .TRUTH(4'b0110), .HOLD(1)) u_dut_x (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_x)
    );

    typedef struct {
        int         done_at;
        logic [2:0] err;
        logic [1:0] fvec;
        logic       fvalid;
        logic       pass;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   sel_x = 1'b0;

    logic       m_busy, m_done, m_pass, m_fv;
    logic [1:0] m_in, m_fvec;
    logic [2:0] m_err;

    always_comb begin
        m_busy = sel_x ? bus_x.busy       : bus_a.busy;
        m_done = sel_x ? bus_x.done       : bus_a.done;
        m_pass = sel_x ? bus_x.pass       : bus_a.pass;
        m_fv   = sel_x ? bus_x.fail_valid : bus_a.fail_valid;
        m_in   = sel_x ? bus_x.dut_in     : bus_a.dut_in;
        m_fvec = sel_x ? bus_x.fail_vec   : bus_a.fail_vec;
        m_err  = sel_x ? bus_x.err_count  : bus_a.err_count;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the gate model against the truth table for all four vectors
    function automatic exp_t predict(input int mode, input logic [3:0] truth, input int hold);
        exp_t e;
        e.done_at = 4 * (hold + 1) + 1;
        e.err     = '0;
        e.fvec    = '0;
        e.fvalid  = 1'b0;
        for (int v = 0; v < 4; v++) begin
            if (dut_model(mode, v[1:0]) !== truth[v]) begin
                e.err++;
                if (!e.fvalid) begin
                    e.fvalid = 1'b1;
                    e.fvec   = v[1:0];
                end
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic drive_start(input bit use_x, input bit val);
        if (use_x) bus_x.start = val;
        else       bus_a.start = val;
    endtask

    // Leaves the bench sampling cycle t0+1 of the new run
    task automatic pulse_start(input bit use_x);
        sel_x = use_x;
        drive_start(use_x, 1'b1);
        step();
        drive_start(use_x, 1'b0);
    endtask

    task automatic run(input int hold, input int rep_a, input int rep_b,
                       input int rst_at, input bit track);
        int   k   = 1;
        bit   got = 1'b0;
        exp_t e;
        while (!got && k <= 300) begin
            if (m_done) begin
                got = 1'b1;
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_cycle", k, e.done_at);
                    check("err_count", m_err, e.err);
                    check("fail_valid", m_fv, e.fvalid);
                    if (e.fvalid) check("fail_vec", m_fvec, e.fvec);
                    check("pass", m_pass, e.pass);
                    check("done_busy", m_busy, 1'b0);
                    check("done_dut_in", m_in, 2'd0);
                end
            end else begin
                if (track && (k % (hold + 1) == 1)) begin
                    check("dut_in_step", m_in, (k - 1) / (hold + 1));
                    check("busy_run", m_busy, 1'b1);
                end
                if (k == rst_at) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    check("rst_busy", m_busy, 1'b0);
                    check("rst_done", m_done, 1'b0);
                    check("rst_dut_in", m_in, 2'd0);
                    check("rst_err", m_err, 3'd0);
                    return;
                end
                if (k == rep_a || k == rep_b) drive_start(sel_x, 1'b1);
                step();
                drive_start(sel_x, 1'b0);
                k++;
            end
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        reset       = 1'b1;
        bus_a.start = 1'b0;
        bus_x.start = 1'b0;
        mode_a      = 0;
        repeat (3) step();
        reset = 1'b0;

        check("reset_busy", bus_a.busy, 1'b0);
        check("reset_done", bus_a.done, 1'b0);
        check("reset_pass", bus_a.pass, 1'b0);
        check("reset_err", bus_a.err_count, 3'd0);
        check("reset_fail_valid", bus_a.fail_valid, 1'b0);
        check("reset_dut_in", bus_a.dut_in, 2'd0);
        check("reset_x_done", bus_x.done, 1'b0);

        // ideal And
        sb.push_back(predict(0, 4'b1000, 10));
        pulse_start(1'b0);
        run(10, -1, -1, -1, 1'b1);

        // stuck-at-0, restarted from DONE
        mode_a = 1;
        sb.push_back(predict(1, 4'b1000, 10));
        pulse_start(1'b0);
        run(10, -1, -1, -1, 1'b0);

        // Nand against an And table
        mode_a = 2;
        sb.push_back(predict(2, 4'b1000, 10));
        pulse_start(1'b0);
        run(10, -1, -1, -1, 1'b0);

        // start re-pulsed mid-run must not disturb it
        mode_a = 0;
        sb.push_back(predict(0, 4'b1000, 10));
        pulse_start(1'b0);
        run(10, 5, 30, -1, 1'b1);

        // reset mid-run, then a fresh run
        pulse_start(1'b0);
        run(10, -1, -1, 20, 1'b0);
        sb.push_back(predict(0, 4'b1000, 10));
        pulse_start(1'b0);
        run(10, -1, -1, -1, 1'b1);

        // Xor checker with HOLD=1, run twice back to back
        sb.push_back(predict(3, 4'b0110, 1));
        pulse_start(1'b1);
        run(1, -1, -1, -1, 1'b1);
        repeat (3) step();
        check("x_done_held", m_done, 1'b1);
        check("x_pass_held", m_pass, 1'b1);
        sb.push_back(predict(3, 4'b0110, 1));
        pulse_start(1'b1);
        check("x_restart_done_drop", m_done, 1'b0);
        check("x_restart_err_clear", m_err, 3'd0);
        run(1, -1, -1, -1, 1'b1);

        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
